sram_slot_scheduler: RTL and testbench

SRAM_SLOT_SCHEDULER -- requirements
Module: sram_slot_scheduler

---
 rtl/sram_slot_scheduler_if.sv | 35 +++
 rtl/sram_slot_scheduler.sv | 82 ++++++++
 tb/tb_sram_slot_scheduler.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sram_slot_scheduler_if.sv
// sram_slot_scheduler_if: client request/grant lines and SRAM pin bundle for the slot scheduler
interface sram_slot_scheduler_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic                  i_frame_start;
    logic [2:0]            i_req;
    logic [2:0]            i_we_n;
    logic [3*ADDR_W-1:0]   i_addr;
    logic [3*DATA_W-1:0]   i_wdata;
    logic [2:0]            o_gnt;
    logic [2:0]            o_done;
    logic [DATA_W-1:0]     o_rdata;
    logic [ADDR_W-1:0]     o_sram_addr;
    logic [DATA_W-1:0]     o_sram_wdata;
    logic                  o_sram_oe;
    logic                  o_sram_we_n;
    logic [DATA_W-1:0]     i_sram_rdata;
    logic                  o_busy;
    logic                  o_frame_done;
    logic                  o_overrun;
    logic                  i_clr_overrun;

    modport slave (
        input  i_frame_start, i_req, i_we_n, i_addr, i_wdata, i_sram_rdata, i_clr_overrun,
        output o_gnt, o_done, o_rdata, o_sram_addr, o_sram_wdata, o_sram_oe, o_sram_we_n,
               o_busy, o_frame_done, o_overrun
    );

    modport master (
        output i_frame_start, i_req, i_we_n, i_addr, i_wdata, i_sram_rdata, i_clr_overrun,
        input  o_gnt, o_done, o_rdata, o_sram_addr, o_sram_wdata, o_sram_oe, o_sram_we_n,
               o_busy, o_frame_done, o_overrun
    );
endinterface

// File: rtl/sram_slot_scheduler.sv
// sram_slot_scheduler: per-sample TDM arbiter giving three clients one SRAM access each, in fixed order
module sram_slot_scheduler #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 16,
    parameter int RD_WAIT = 2
) (
    input logic                   i_clk,
    input logic                   i_rst,
    sram_slot_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SCAN, ACCESS, TURN} state_t;
    localparam logic [3:0] LAST = 4'(RD_WAIT);

    state_t              state, state_nx;
    logic [1:0]          ptr;
    logic [3:0]          cnt;
    logic [ADDR_W-1:0]   addr_q, sel_addr;
    logic [DATA_W-1:0]   wdata_q, sel_wdata;
    logic                we_n_q;
    logic [3:0]          req_ext, we_ext;
    logic                req_hit, last, acc, wr;

    // slot 3 is the end-of-frame marker, so pad the per-client vectors to four entries
    assign req_ext   = {1'b0, bus.i_req};
    assign we_ext    = {1'b1, bus.i_we_n};
    assign req_hit   = req_ext[ptr];
    assign last      = cnt == LAST;
    assign acc       = state == ACCESS;
    assign wr        = acc && !we_n_q;
    assign sel_addr  = ptr == 2'd0 ? bus.i_addr[0 +: ADDR_W] :
                       ptr == 2'd1 ? bus.i_addr[ADDR_W +: ADDR_W] : bus.i_addr[2*ADDR_W +: ADDR_W];
    assign sel_wdata = ptr == 2'd0 ? bus.i_wdata[0 +: DATA_W] :
                       ptr == 2'd1 ? bus.i_wdata[DATA_W +: DATA_W] : bus.i_wdata[2*DATA_W +: DATA_W];

    always_ff @(posedge i_clk)
        state <= i_rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = bus.i_frame_start ? SCAN : IDLE;
            SCAN:    state_nx = ptr == 2'd3 ? IDLE : req_hit ? ACCESS : SCAN;
            ACCESS:  state_nx = last ? TURN : ACCESS;
            default: state_nx = SCAN;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr           <= 2'd0;
            cnt           <= 4'd0;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_n_q        <= 1'b1;
            bus.o_rdata   <= '0;
            bus.o_overrun <= 1'b0;
        end else begin
            ptr <= state == IDLE ? 2'd0 : (state == SCAN && !req_hit) || state == TURN ? ptr + 2'd1 : ptr;
            cnt <= acc ? cnt + 4'd1 : 4'd0;
            if (state == SCAN && req_hit) begin
                addr_q  <= sel_addr;
                wdata_q <= sel_wdata;
                we_n_q  <= we_ext[ptr];
            end
            if (acc && last && we_n_q)
                bus.o_rdata <= bus.i_sram_rdata;
            // a new overrun outranks a simultaneous clear
            bus.o_overrun <= bus.i_frame_start && state != IDLE ? 1'b1 : bus.i_clr_overrun ? 1'b0 : bus.o_overrun;
        end
    end

    always_comb begin
        bus.o_gnt        = acc ? 3'b001 << ptr : 3'b000;
        bus.o_done       = state == TURN ? 3'b001 << ptr : 3'b000;
        bus.o_sram_addr  = acc ? addr_q : '0;
        bus.o_sram_wdata = wr ? wdata_q : '0;
        bus.o_sram_oe    = wr;
        bus.o_sram_we_n  = !(wr && !last);
        bus.o_busy       = state != IDLE;
        bus.o_frame_done = state == SCAN && ptr == 2'd3;
    end
endmodule

// File: tb/tb_sram_slot_scheduler.sv
// tb_sram_slot_scheduler: frame-level schedule model checked cycle by cycle against the scheduler
module tb_sram_slot_scheduler;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int RW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sram_slot_scheduler_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    sram_slot_scheduler #(.ADDR_W(AW), .DATA_W(DW), .RD_WAIT(RW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    logic [DW-1:0] sram    [256] = '{default: '0};
    logic [DW-1:0] ref_mem [256] = '{default: '0};
    always @(posedge clk)
        if (!bus.o_sram_we_n && bus.o_sram_oe) sram[bus.o_sram_addr[7:0]] <= bus.o_sram_wdata;
    assign bus.i_sram_rdata = sram[bus.o_sram_addr[7:0]];

    int n_chk = 0;
    int n_fail = 0;
    logic [DW-1:0] exp_rdata = '0;
    logic exp_ovr = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_pins(input string tag);
        chk({tag, "_gnt"}, 32'(bus.o_gnt), 0);
        chk({tag, "_done"}, 32'(bus.o_done), 0);
        chk({tag, "_oe"}, 32'(bus.o_sram_oe), 0);
        chk({tag, "_we_n"}, 32'(bus.o_sram_we_n), 1);
        chk({tag, "_addr"}, 32'(bus.o_sram_addr), 0);
        chk({tag, "_busy"}, 32'(bus.o_busy), 0);
    endtask

    // Builds the expected timeline of one frame from slot arithmetic, then compares every cycle.
    task automatic run_frame(input logic [2:0] req, input logic [2:0] we_n, input logic [3*AW-1:0] addr,
                             input logic [3*DW-1:0] wdata, input bit ovr, input bit pert);
        logic [2:0]    e_gnt [64];
        logic [2:0]    e_done [64];
        logic          e_fd [64], e_busy [64], e_oe [64], e_we_n [64], e_rd_v [64];
        logic [AW-1:0] e_addr [64];
        logic [DW-1:0] e_wd [64], e_rd [64];
        logic [AW-1:0] a;
        int t, ovr_c, pert_c;
        for (int c = 0; c < 64; c++) begin
            e_gnt[c] = 0; e_done[c] = 0; e_fd[c] = 0; e_busy[c] = 0; e_oe[c] = 0;
            e_we_n[c] = 1; e_rd_v[c] = 0; e_addr[c] = 0; e_wd[c] = 0; e_rd[c] = 0;
        end
        t = 1; ovr_c = -1; pert_c = -1;
        for (int k = 0; k < 3; k++) begin
            if (req[k]) begin
                a = addr[k*AW +: AW];
                for (int j = 0; j <= RW; j++) begin
                    e_gnt[t+1+j]  = 3'(1 << k);
                    e_addr[t+1+j] = a;
                    e_oe[t+1+j]   = !we_n[k];
                    e_we_n[t+1+j] = we_n[k] || j == RW;
                    e_wd[t+1+j]   = we_n[k] ? '0 : wdata[k*DW +: DW];
                end
                e_done[t+RW+2] = 3'(1 << k);
                if (we_n[k]) begin
                    e_rd_v[t+RW+2] = 1;
                    e_rd[t+RW+2] = ref_mem[a[7:0]];
                end else ref_mem[a[7:0]] = wdata[k*DW +: DW];
                if (k == 1) ovr_c = t + 1;
                if (k == 2) pert_c = t + 2;
                t += RW + 3;
            end else t++;
        end
        e_fd[t] = 1;
        for (int c = 1; c <= t; c++) e_busy[c] = 1;
        bus.i_req = req; bus.i_we_n = we_n; bus.i_addr = addr; bus.i_wdata = wdata;
        bus.i_frame_start = 1'b1;
        @(posedge clk);
        #1 bus.i_frame_start = 1'b0;
        for (int c = 1; c <= t + 1; c++) begin
            @(negedge clk);
            if (e_rd_v[c]) exp_rdata = e_rd[c];
            if (ovr && c == ovr_c + 1) exp_ovr = 1'b1;
            chk($sformatf("gnt@%0d", c), 32'(bus.o_gnt), 32'(e_gnt[c]));
            chk($sformatf("done@%0d", c), 32'(bus.o_done), 32'(e_done[c]));
            chk($sformatf("frame_done@%0d", c), 32'(bus.o_frame_done), 32'(e_fd[c]));
            chk($sformatf("busy@%0d", c), 32'(bus.o_busy), 32'(e_busy[c]));
            chk($sformatf("addr@%0d", c), 32'(bus.o_sram_addr), 32'(e_addr[c]));
            chk($sformatf("oe@%0d", c), 32'(bus.o_sram_oe), 32'(e_oe[c]));
            chk($sformatf("we_n@%0d", c), 32'(bus.o_sram_we_n), 32'(e_we_n[c]));
            if (e_oe[c] || e_gnt[c] == 0) chk($sformatf("wdata@%0d", c), 32'(bus.o_sram_wdata), 32'(e_wd[c]));
            chk($sformatf("rdata@%0d", c), 32'(bus.o_rdata), 32'(exp_rdata));
            chk($sformatf("overrun@%0d", c), 32'(bus.o_overrun), 32'(exp_ovr));
            if (ovr && c == ovr_c) begin bus.i_frame_start = 1'b1; bus.i_clr_overrun = 1'b1; end
            if (ovr && c == ovr_c + 1) begin bus.i_frame_start = 1'b0; bus.i_clr_overrun = 1'b0; end
            if (pert && c == pert_c) begin
                bus.i_req[2] = 1'b0;
                bus.i_addr[2*AW +: AW] = bus.i_addr[2*AW +: AW] ^ 20'h000F5;
            end
        end
    endtask

    logic [3*AW-1:0] ra;
    logic [3*DW-1:0] rd;

    initial begin
        rst = 1'b1;
        bus.i_frame_start = 0; bus.i_req = 0; bus.i_we_n = 3'b111; bus.i_addr = '0;
        bus.i_wdata = '0; bus.i_clr_overrun = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_pins("reset");
        chk("reset_rdata", 32'(bus.o_rdata), 0);
        chk("reset_overrun", 32'(bus.o_overrun), 0);
        chk("reset_frame_done", 32'(bus.o_frame_done), 0);
        chk("reset_wdata", 32'(bus.o_sram_wdata), 0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(3'b001, 3'b110, {20'h0, 20'h0, 20'h00010}, {16'h0, 16'h0, 16'h1234}, 0, 0);
        run_frame(3'b111, 3'b011, {20'h00005, 20'h00010, 20'h00003}, {16'h5a5a, 16'h0, 16'h0}, 0, 0);
        chk("client1_read_0x1234", 32'(ref_mem[8'h10]), 32'h1234);
        run_frame(3'b000, 3'b111, '0, '0, 0, 0);
        run_frame(3'b111, 3'b101, {20'h00007, 20'h00002, 20'h00010}, {16'h0, 16'h7777, 16'h0}, 1, 0);
        bus.i_clr_overrun = 1'b1;
        @(posedge clk);
        #1 bus.i_clr_overrun = 1'b0;
        exp_ovr = 1'b0;
        @(negedge clk);
        chk("overrun_cleared", 32'(bus.o_overrun), 0);
        run_frame(3'b100, 3'b111, {20'h00005, 20'h0, 20'h0}, '0, 0, 1);

        for (int f = 0; f < 40; f++) begin
            for (int k = 0; k < 3; k++) begin
                ra[k*AW +: AW] = AW'($urandom_range(0, 15));
                rd[k*DW +: DW] = DW'($urandom);
            end
            run_frame(3'($urandom), 3'($urandom), ra, rd, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
        end

        // reset in the middle of a write access, on its second cycle
        bus.i_req = 3'b001; bus.i_we_n = 3'b110; bus.i_addr = {20'h0, 20'h0, 20'h00080};
        bus.i_wdata = {16'h0, 16'h0, 16'hbeef};
        bus.i_frame_start = 1'b1;
        @(posedge clk);
        #1 bus.i_frame_start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_reset_gnt", 32'(bus.o_gnt), 1);
        chk("pre_reset_we_n", 32'(bus.o_sram_we_n), 0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        exp_rdata = '0;
        chk_idle_pins("mid_reset");
        chk("mid_reset_rdata", 32'(bus.o_rdata), 32'(exp_rdata));
        rst = 1'b0;
        @(negedge clk);
        chk_idle_pins("post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
